bmnc_merge_ctrl: RTL

//  Sequencer for the bitonic merge network (BMNC): pairs one N-element block from stream A with one from stream B.

---
 rtl/bmnc_merge_ctrl_pkg.sv | 31 +++
 rtl/bmnc_result_fifo.sv | 88 ++++++++
 rtl/bmnc_merge_ctrl.sv | 84 ++++++++
 3 files changed

// File: rtl/bmnc_merge_ctrl_pkg.sv
// Shared constants, types and helpers for the BMNC merge sequencer.
package bmnc_merge_ctrl_pkg;

    localparam int LOG_N      = 3;
    localparam int N          = 1 << LOG_N;
    localparam int ELEM_W     = 4;
    localparam int BMNC_LAT   = 4;
    localparam int FIFO_DEPTH = 8;

    localparam int BLOCK_W = N * ELEM_W;
    localparam int IN_W    = 2 * BLOCK_W;
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = FIFO_AW + 1;
    // Occupancy (in-flight + buffered) needs one extra bit of headroom.
    localparam int OCC_W   = CNT_W + 1;
    localparam int LCNT_W  = 16;

    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [OCC_W-1:0]   occ_t;

    // Number of pairs currently travelling through the network.
    function automatic occ_t popcount_pipe(input logic [BMNC_LAT-1:0] bits);
        occ_t acc;
        acc = {OCC_W{1'b0}};
        for (int i = 0; i < BMNC_LAT; i++) begin
            acc = acc + occ_t'(bits[i]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/bmnc_result_fifo.sv
// Result buffer: synchronous FIFO with a registered head word and count.
// The head register holds its last value while the FIFO is empty.
module bmnc_result_fifo
    import bmnc_merge_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en_i,
    input  logic [BLOCK_W-1:0] wr_data_i,
    input  logic               rd_ready_i,
    output logic               rd_valid_o,
    output logic [BLOCK_W-1:0] rd_data_o,
    output logic [CNT_W-1:0]   count_o
);

    logic [BLOCK_W-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   remain_s;
    logic [BLOCK_W-1:0] head_q, head_d;
    logic               valid_q, valid_d;
    logic               push_s, pop_s;

    // Pointer, count and head-word next-state computation.
    always_comb begin
        pop_s    = valid_q & rd_ready_i;
        // A write into a full FIFO is only taken when a pop frees the slot.
        push_s   = wr_en_i & ((count_q != CNT_W'(FIFO_DEPTH)) | pop_s);
        remain_s = count_q - CNT_W'(pop_s);
        count_d  = remain_s + CNT_W'(push_s);

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // New head comes from storage, or bypasses straight from the
        // write port when the entry it needs is being written this edge.
        if (count_d != {CNT_W{1'b0}}) begin
            if (remain_s == {CNT_W{1'b0}}) begin
                head_d = wr_data_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end else begin
            head_d = head_q;
        end

        valid_d = (count_d != {CNT_W{1'b0}});
    end

    // Storage array write; contents need no reset since count gates use.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Control and head registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {FIFO_AW{1'b0}};
            rd_ptr_q <= {FIFO_AW{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            head_q   <= {BLOCK_W{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    assign rd_valid_o = valid_q;
    assign rd_data_o  = head_q;
    assign count_o    = count_q;

endmodule

// File: rtl/bmnc_merge_ctrl.sv
// BMNC merge sequencer: pairs A/B blocks, launches them into the
// non-stallable merge network and buffers results with credit control.
module bmnc_merge_ctrl
    import bmnc_merge_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [BLOCK_W-1:0] a_data,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic [BLOCK_W-1:0] b_data,
    input  logic               b_valid,
    output logic               b_ready,
    output logic [IN_W-1:0]    bmnc_in,
    input  logic [BLOCK_W-1:0] bmnc_out,
    output logic [BLOCK_W-1:0] m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               idle,
    output logic [LCNT_W-1:0]  launch_cnt
);

    logic [BMNC_LAT-1:0] vld_pipe_q, vld_pipe_d;
    logic [IN_W-1:0]     bmnc_in_q, bmnc_in_d;
    logic [LCNT_W-1:0]   launch_cnt_q, launch_cnt_d;
    logic [CNT_W-1:0]    fifo_count_s;
    occ_t                occupancy_s;
    logic                credit_ok_s;
    logic                launch_s;
    logic                push_s;

    // Launch decision from registered occupancy only, so m_ready never
    // reaches a_ready combinationally and a same-cycle pop frees no credit.
    always_comb begin
        occupancy_s = popcount_pipe(vld_pipe_q) + occ_t'(fifo_count_s);
        credit_ok_s = (occupancy_s < occ_t'(FIFO_DEPTH));
        launch_s    = a_valid & b_valid & credit_ok_s & ~reset;
        push_s      = vld_pipe_q[BMNC_LAT-1];
    end

    // Next-state for the valid pipe, network input register and counter.
    always_comb begin
        vld_pipe_d = {vld_pipe_q[BMNC_LAT-2:0], launch_s};
        if (launch_s) begin
            bmnc_in_d    = {a_data, b_data};
            launch_cnt_d = launch_cnt_q + 16'd1;
        end else begin
            bmnc_in_d    = bmnc_in_q;
            launch_cnt_d = launch_cnt_q;
        end
    end

    // State registers; reset discards every in-flight pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe_q   <= {BMNC_LAT{1'b0}};
            bmnc_in_q    <= {IN_W{1'b0}};
            launch_cnt_q <= {LCNT_W{1'b0}};
        end else begin
            vld_pipe_q   <= vld_pipe_d;
            bmnc_in_q    <= bmnc_in_d;
            launch_cnt_q <= launch_cnt_d;
        end
    end

    bmnc_result_fifo u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (push_s),
        .wr_data_i  (bmnc_out),
        .rd_ready_i (m_ready),
        .rd_valid_o (m_valid),
        .rd_data_o  (m_data),
        .count_o    (fifo_count_s)
    );

    assign a_ready    = launch_s;
    assign b_ready    = launch_s;
    assign bmnc_in    = bmnc_in_q;
    assign launch_cnt = launch_cnt_q;
    assign idle       = (vld_pipe_q == {BMNC_LAT{1'b0}}) &
                        (fifo_count_s == {CNT_W{1'b0}});

endmodule
